// File: rtl/fpu_cmp_pkg.sv
// Shared types and helpers for the FP compare/min-max pipeline.
package fpu_cmp_pkg;

  typedef enum logic [2:0] {
    FLE  = 3'b000,
    FLT  = 3'b001,
    FEQ  = 3'b010,
    FMIN = 3'b011,
    FMAX = 3'b100
  } cmp_op_e;

  typedef enum logic [2:0] {ZERO, SUBNORM, NORM, INF, QNAN, SNAN} fp_class_e;

  localparam int FP_MAX_W = 64;

  // Canonical quiet NaN: sign 0, exponent all-ones, fraction MSB set, rest zero.
  function automatic logic [FP_MAX_W-1:0] canonical_nan(input int exp_w, input int man_w);
    logic [FP_MAX_W-1:0] v;
    v = '0;
    for (int i = 0; i < FP_MAX_W; i++)
      if ((i >= man_w - 1) && (i < man_w + exp_w)) v[i] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/fpu_classify.sv
// Combinational IEEE-754 operand classifier (zero/subnormal/normal/inf/qNaN/sNaN) plus sign.
module fpu_classify
  import fpu_cmp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [EXP_W+MAN_W:0] x,
  output fp_class_e            cls,
  output logic                 sign
);

  logic [EXP_W-1:0] exp_f;
  logic [MAN_W-1:0] man_f;

  assign sign  = x[EXP_W+MAN_W];
  assign exp_f = x[EXP_W+MAN_W-1:MAN_W];
  assign man_f = x[MAN_W-1:0];

  always_comb begin
    cls = NORM;
    if (&exp_f) begin
      if (man_f == '0)        cls = INF;
      else if (man_f[MAN_W-1]) cls = QNAN;
      else                     cls = SNAN;
    end else if (exp_f == '0) begin
      cls = (man_f == '0) ? ZERO : SUBNORM;
    end
  end

endmodule

// File: rtl/fpu_compare_pipe.sv
// Pipelined FP compare / min-max unit with valid-ready handshake and NV flag accounting.
// FPU_CMP_MINMAX_EN enables FMIN/FMAX; otherwise those opcodes are reported as illegal.
module fpu_compare_pipe
  import fpu_cmp_pkg::*;
#(
  parameter int EXP_W  = 8,
  parameter int MAN_W  = 23,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [EXP_W+MAN_W:0]     in_a,
  input  logic [EXP_W+MAN_W:0]     in_b,
  input  logic [2:0]               in_op,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     out_result,
  output logic                     out_invalid,
  output logic [TAG_W-1:0]         out_tag,
  input  logic                     flags_clr,
  output logic                     sticky_nv,
  output logic [CNT_W-1:0]         nv_count
);

  localparam int W = 1 + EXP_W + MAN_W;
`ifdef FPU_CMP_MINMAX_EN
  localparam logic [FP_MAX_W-1:0] CNAN_FULL = canonical_nan(EXP_W, MAN_W);
  localparam logic [W-1:0]        CNAN      = CNAN_FULL[W-1:0];
`endif

  typedef struct packed {
    logic [2:0]       op;
`ifdef FPU_CMP_MINMAX_EN
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic             ltz;
`endif
    logic [TAG_W-1:0] tag;
    fp_class_e        cls_a;
    fp_class_e        cls_b;
    logic             lt;
    logic             eq;
  } pay_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  function automatic logic [W:0] eval_op(input pay_t p);
    logic         nan_a, nan_b, nan_any, snan_any, inv;
    logic [W-1:0] res;
    nan_a    = (p.cls_a == QNAN) || (p.cls_a == SNAN);
    nan_b    = (p.cls_b == QNAN) || (p.cls_b == SNAN);
    nan_any  = nan_a || nan_b;
    snan_any = (p.cls_a == SNAN) || (p.cls_b == SNAN);
    res = '0;
    inv = 1'b0;
    case (p.op)
      FEQ: begin res[0] = !nan_any && p.eq;           inv = snan_any; end
      FLT: begin res[0] = !nan_any && p.lt;           inv = nan_any;  end
      FLE: begin res[0] = !nan_any && (p.lt || p.eq); inv = nan_any;  end
`ifdef FPU_CMP_MINMAX_EN
      FMIN, FMAX: begin
        inv = snan_any;
        if (nan_a && nan_b) res = CNAN;
        else if (nan_a)     res = p.b;
        else if (nan_b)     res = p.a;
        else                res = ((p.op == FMIN) == p.ltz) ? p.a : p.b;
      end
`endif
      default: begin res = '0; inv = 1'b1; end
    endcase
    return {inv, res};
  endfunction

  fp_class_e    cls_a, cls_b;
  logic         sign_a, sign_b, both_zero, ltz;
  logic [W-2:0] mag_a, mag_b;
  pay_t         pay_in, pay_last;
  logic         vld_last;
  logic [STAGES-1:0] vld_p, adv;

  fpu_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (.x(in_a), .cls(cls_a), .sign(sign_a));
  fpu_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (.x(in_b), .cls(cls_b), .sign(sign_b));

  // Sign-magnitude ordering; ltz orders -0 below +0, lt/eq treat the zeros as equal.
  assign mag_a     = in_a[W-2:0];
  assign mag_b     = in_b[W-2:0];
  assign both_zero = (cls_a == ZERO) && (cls_b == ZERO);
  assign ltz       = (sign_a != sign_b) ? sign_a : (sign_a ? (mag_a > mag_b) : (mag_a < mag_b));

  always_comb begin
    pay_in       = '0;
    pay_in.op    = in_op;
`ifdef FPU_CMP_MINMAX_EN
    pay_in.a     = in_a;
    pay_in.b     = in_b;
    pay_in.ltz   = ltz;
`endif
    pay_in.tag   = in_tag;
    pay_in.cls_a = cls_a;
    pay_in.cls_b = cls_b;
    pay_in.lt    = ltz && !both_zero;
    pay_in.eq    = both_zero || (in_a == in_b);
  end

  always_comb begin
    adv = '0;
    adv[STAGES-1] = !vld_p[STAGES-1] || out_ready;
    for (int k = STAGES - 2; k >= 0; k--) adv[k] = !vld_p[k] || adv[k+1];
  end

  assign in_ready  = adv[0];
  assign out_valid = vld_p[STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p <= '0;
    end else begin
      if (adv[0]) vld_p[0] <= in_valid;
      for (int k = 1; k < STAGES; k++)
        if (adv[k]) vld_p[k] <= vld_p[k-1];
    end
  end

  generate
    if (STAGES == 1) begin : g_fold
      assign pay_last = pay_in;
      assign vld_last = in_valid;
    end else begin : g_pipe
      pay_t pay_p [STAGES-1];
      // Stage 0 holds class and compare flags; later stages up to the result are plain copies.
      always_ff @(posedge clk) begin
        if (adv[0] && in_valid) pay_p[0] <= pay_in;
        for (int k = 1; k < STAGES - 1; k++)
          if (adv[k] && vld_p[k-1]) pay_p[k] <= pay_p[k-1];
      end
      assign pay_last = pay_p[STAGES-2];
      assign vld_last = vld_p[STAGES-2];
    end
  endgenerate

  // Result stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_result  <= '0;
      out_invalid <= 1'b0;
      out_tag     <= '0;
    end else if (adv[STAGES-1] && vld_last) begin
      {out_invalid, out_result} <= eval_op(pay_last);
      out_tag                   <= pay_last.tag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_nv <= 1'b0;
      nv_count  <= '0;
    end else if (flags_clr) begin
      sticky_nv <= 1'b0;
      nv_count  <= '0;
    end else if (out_valid && out_ready && out_invalid) begin
      sticky_nv <= 1'b1;
      nv_count  <= sat_inc(nv_count);
    end
  end

endmodule

// File: tb/tb_fpu_compare_pipe.sv
// Directed self-checking bench for fpu_compare_pipe (default parameters, STAGES=2).
module tb_fpu_compare_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] in_a, in_b;
  logic [2:0]  in_op;
  logic [3:0]  in_tag;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic        out_invalid;
  logic [3:0]  out_tag;
  logic        flags_clr;
  logic        sticky_nv;
  logic [15:0] nv_count;

  int checks = 0;
  int errors = 0;

  localparam logic [2:0] OP_FLE = 3'b000, OP_FLT = 3'b001, OP_FEQ = 3'b010,
                         OP_FMIN = 3'b011, OP_FMAX = 3'b100, OP_BAD = 3'b101;

  fpu_compare_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_invalid(out_invalid), .out_tag(out_tag), .flags_clr(flags_clr),
    .sticky_nv(sticky_nv), .nv_count(nv_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_op(input string nm, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [3:0] tag,
                        input logic [31:0] er, input logic ei, input logic clr);
    int lat;
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, "_lat"}, 64'(lat), 64'd2);
    chk({nm, "_res"}, 64'(out_result), 64'(er));
    chk({nm, "_inv"}, 64'(out_invalid), 64'(ei));
    chk({nm, "_tag"}, 64'(out_tag), 64'(tag));
    flags_clr = clr;
    @(negedge clk);
    flags_clr = 1'b0;
  endtask

  int          sent, rcvd;
  logic        saw_drop, prev_stall;
  logic [36:0] held;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; in_tag = '0;
    out_ready = 1'b1; flags_clr = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_result", 64'(out_result), 64'd0);
    chk("rst_out_invalid", 64'(out_invalid), 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    chk("rst_sticky", 64'(sticky_nv), 64'd0);
    chk("rst_count", 64'(nv_count), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    run_op("flt_1_2",    OP_FLT, 32'h3F800000, 32'h40000000, 4'h1, 32'd1, 1'b0, 1'b0);
    run_op("feq_zeros",  OP_FEQ, 32'h80000000, 32'h00000000, 4'h2, 32'd1, 1'b0, 1'b0);
    run_op("fle_m2_m1",  OP_FLE, 32'hC0000000, 32'hBF800000, 4'h3, 32'd1, 1'b0, 1'b0);
    run_op("flt_m1_m2",  OP_FLT, 32'hBF800000, 32'hC0000000, 4'h4, 32'd0, 1'b0, 1'b0);
    run_op("flt_zeros",  OP_FLT, 32'h80000000, 32'h00000000, 4'h5, 32'd0, 1'b0, 1'b0);
    run_op("feq_qnan",   OP_FEQ, 32'h7FC00000, 32'h3F800000, 4'h6, 32'd0, 1'b0, 1'b0);
    run_op("feq_snan",   OP_FEQ, 32'h7F800001, 32'h3F800000, 4'h7, 32'd0, 1'b1, 1'b0);
    run_op("fle_qnan",   OP_FLE, 32'h7FC00000, 32'h3F800000, 4'h8, 32'd0, 1'b1, 1'b0);
    run_op("illegal_op", OP_BAD, 32'h3F800000, 32'h3F800000, 4'h9, 32'd0, 1'b1, 1'b0);
`ifdef FPU_CMP_MINMAX_EN
    run_op("fmin_zeros", OP_FMIN, 32'h00000000, 32'h80000000, 4'hA, 32'h80000000, 1'b0, 1'b0);
    run_op("fmax_zeros", OP_FMAX, 32'h80000000, 32'h00000000, 4'hB, 32'h00000000, 1'b0, 1'b0);
    run_op("fmax_qnan",  OP_FMAX, 32'h7FC00000, 32'h40000000, 4'hC, 32'h40000000, 1'b0, 1'b0);
    run_op("fmin_2nan",  OP_FMIN, 32'h7F800001, 32'h7FC00000, 4'hD, 32'h7FC00000, 1'b1, 1'b0);
    run_op("fmin_neg",   OP_FMIN, 32'h3F800000, 32'hC0000000, 4'hE, 32'hC0000000, 1'b0, 1'b0);
`else
    run_op("fmin_off",   OP_FMIN, 32'h00000000, 32'h80000000, 4'hA, 32'd0, 1'b1, 1'b0);
    run_op("fmax_off",   OP_FMAX, 32'h3F800000, 32'h40000000, 4'hB, 32'd0, 1'b1, 1'b0);
`endif

    // Stream of 8 ops with the consumer stalled on cycles 3..6.
    sent = 0; rcvd = 0; saw_drop = 1'b0; prev_stall = 1'b0; held = '0;
    for (int c = 0; c < 40 && rcvd < 8; c++) begin
      @(negedge clk);
      out_ready = !(c >= 3 && c <= 6);
      in_valid  = (sent < 8);
      in_op     = OP_FLT;
      in_tag    = 4'(sent);
      in_a      = sent[0] ? 32'h40000000 : 32'h3F800000;
      in_b      = 32'h3FC00000;
      #1;
      if (prev_stall)
        chk("stall_hold", 64'({out_valid, out_invalid, out_tag, out_result[30:0]}), 64'(held));
      if (in_valid && !in_ready) saw_drop = 1'b1;
      if (out_valid && out_ready) begin
        chk("stream_tag", 64'(out_tag), 64'(rcvd[3:0]));
        chk("stream_res", 64'(out_result), 64'(!rcvd[0]));
        rcvd++;
      end
      prev_stall = out_valid && !out_ready;
      held = {out_valid, out_invalid, out_tag, out_result[30:0]};
      if (in_valid && in_ready) sent++;
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    chk("stream_rcvd", 64'(rcvd), 64'd8);
    chk("stream_sent", 64'(sent), 64'd8);
    chk("stream_ready_drop", 64'(saw_drop), 64'd1);
    @(negedge clk);
    chk("stream_drained", 64'(out_valid), 64'd0);

    // Invalid-flag accounting.
    flags_clr = 1'b1;
    @(negedge clk);
    flags_clr = 1'b0;
    chk("clr_count", 64'(nv_count), 64'd0);
    chk("clr_sticky", 64'(sticky_nv), 64'd0);
    run_op("nv1", OP_FLT, 32'h7FC00000, 32'h3F800000, 4'h1, 32'd0, 1'b1, 1'b0);
    run_op("nv2", OP_FLE, 32'h3F800000, 32'h7F800001, 4'h2, 32'd0, 1'b1, 1'b0);
    run_op("nv3", OP_BAD, 32'h3F800000, 32'h3F800000, 4'h3, 32'd0, 1'b1, 1'b0);
    chk("nv_count_3", 64'(nv_count), 64'd3);
    chk("sticky_3", 64'(sticky_nv), 64'd1);
    run_op("nv4_clr", OP_FLT, 32'h7FC00000, 32'h3F800000, 4'h4, 32'd0, 1'b1, 1'b1);
    chk("nv_count_clr_wins", 64'(nv_count), 64'd0);
    chk("sticky_clr_wins", 64'(sticky_nv), 64'd0);
    run_op("nv5", OP_FLT, 32'h7FC00000, 32'h3F800000, 4'h5, 32'd0, 1'b1, 1'b0);
    chk("nv_count_1", 64'(nv_count), 64'd1);

    // Reset while the pipe holds ops.
    @(negedge clk);
    in_valid = 1'b1; in_op = OP_FLT; in_a = 32'h7FC00000; in_b = 32'h3F800000; in_tag = 4'h6;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_count", 64'(nv_count), 64'd0);
    chk("midrst_sticky", 64'(sticky_nv), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_midrst_empty", 64'(out_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
